// File: rtl/memory_write_ram.sv
// Word RAM behind the output-stream writer: one write per `start`, registered read port.
// Optional MEMORY_W_OOB_ERR_EN adds the sticky `oob_err` output for out-of-range writes.
module memory_write_ram #(
    parameter int SIZE          = 1024,
    parameter int ADDRESS_WIDTH = 10,
    parameter int write_size    = 32,
    parameter int WRITE_CYCLES  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [write_size-1:0]    data_in,
    output logic                     ready,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [write_size-1:0]    rd_data
`ifdef MEMORY_W_OOB_ERR_EN
    ,
    output logic                     oob_err
`endif
);

    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [ADDRESS_WIDTH:0] SIZE_LIM = (ADDRESS_WIDTH + 1)'(SIZE);

    // Contents are not cleared by reset; the zero initialiser only serves simulation.
    logic [write_size-1:0] mem_q [SIZE] = '{default: '0};

    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [write_size-1:0]    wr_data;
    logic [write_size-1:0]    rd_data_q, rd_data_d;

    function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] a);
        return {1'b0, a} < SIZE_LIM;
    endfunction

    generate
        if (WRITE_CYCLES == 1) begin : g_direct
            assign ready   = 1'b1;
            assign wr_en   = start && !reset;
            assign wr_addr = address;
            assign wr_data = data_in;
        end else begin : g_fsm
            localparam int CW = $clog2(WRITE_CYCLES);
            localparam logic [CW-1:0] CNT_LOAD = CW'(WRITE_CYCLES - 1);
            localparam logic [CW-1:0] CNT_ONE  = CW'(1);
            localparam logic ST_IDLE = 1'b0;
            localparam logic ST_BUSY = 1'b1;

            logic                     state_q, state_d;
            logic [CW-1:0]            cnt_q, cnt_d;
            logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
            logic [write_size-1:0]    data_q, data_d;
            logic                     commit;

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    addr_q  <= '0;
                    data_q  <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    addr_q  <= addr_d;
                    data_q  <= data_d;
                end
            end

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                addr_d  = addr_q;
                data_d  = data_q;
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_d = ST_BUSY;
                            cnt_d   = CNT_LOAD;
                            addr_d  = address;
                            data_d  = data_in;
                        end
                    end
                    default: begin
                        cnt_d = cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_d = ST_IDLE;
                        end
                    end
                endcase
            end

            // Commit on the edge where the counter steps from 1 to 0.
            always_comb begin
                ready   = (state_q == ST_IDLE);
                commit  = (state_q == ST_BUSY) && (cnt_q == CNT_ONE);
                wr_en   = commit && !reset;
                wr_addr = addr_q;
                wr_data = data_q;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en && in_range(wr_addr)) begin
            mem_q[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = in_range(rd_addr) ? mem_q[rd_addr[IDX_W-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

`ifdef MEMORY_W_OOB_ERR_EN
    logic oob_err_q, oob_err_d;

    always_comb begin
        oob_err_d = oob_err_q | (start && ready && !in_range(address));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            oob_err_q <= 1'b0;
        end else begin
            oob_err_q <= oob_err_d;
        end
    end

    assign oob_err = oob_err_q;
`endif

endmodule

// File: tb/tb_memory_write_ram.sv
// Self-checking bench for memory_write_ram: three instances (WRITE_CYCLES 1, 3, 4),
// SIZE=1024 with 11-bit addresses so out-of-range writes can be issued.
module tb_memory_write_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_s   [3];
    logic [10:0] addr_s    [3];
    logic [31:0] din_s     [3];
    logic [10:0] rd_addr_s [3];
    logic        ready_s   [3];
    logic [31:0] rd_data_s [3];
`ifdef MEMORY_W_OOB_ERR_EN
    logic        oob_s     [3];
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [3][1024];

    typedef struct {
        int          inst;
        logic [31:0] exp;
        string       name;
    } rd_exp_t;
    rd_exp_t sb[$];

    typedef struct {
        logic [10:0] addr;
        logic [31:0] data;
        logic        exp_ready;
    } wr_vec_t;
    wr_vec_t burst [8];

    always #5 clk = ~clk;

    memory_write_ram #(.SIZE(1024), .ADDRESS_WIDTH(11), .write_size(32), .WRITE_CYCLES(1)) u_dut_wc1 (
        .clk(clk), .reset(reset), .start(start_s[0]), .address(addr_s[0]), .data_in(din_s[0]),
        .ready(ready_s[0]), .rd_addr(rd_addr_s[0]), .rd_data(rd_data_s[0])
`ifdef MEMORY_W_OOB_ERR_EN
        , .oob_err(oob_s[0])
`endif
    );

    memory_write_ram #(.SIZE(1024), .ADDRESS_WIDTH(11), .write_size(32), .WRITE_CYCLES(3)) u_dut_wc3 (
        .clk(clk), .reset(reset), .start(start_s[1]), .address(addr_s[1]), .data_in(din_s[1]),
        .ready(ready_s[1]), .rd_addr(rd_addr_s[1]), .rd_data(rd_data_s[1])
`ifdef MEMORY_W_OOB_ERR_EN
        , .oob_err(oob_s[1])
`endif
    );

    memory_write_ram #(.SIZE(1024), .ADDRESS_WIDTH(11), .write_size(32), .WRITE_CYCLES(4)) u_dut_wc4 (
        .clk(clk), .reset(reset), .start(start_s[2]), .address(addr_s[2]), .data_in(din_s[2]),
        .ready(ready_s[2]), .rd_addr(rd_addr_s[2]), .rd_data(rd_data_s[2])
`ifdef MEMORY_W_OOB_ERR_EN
        , .oob_err(oob_s[2])
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int i, input logic [10:0] a);
        if (a >= 11'd1024) return 32'h0;
        return model[i][a[9:0]];
    endfunction

    // Advance one edge, then compare every read expectation queued for that edge.
    task automatic tick();
        rd_exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, rd_data_s[e.inst], e.exp);
        end
    endtask

    task automatic push_rd(input int i, input logic [10:0] a, input string name);
        rd_addr_s[i] = a;
        sb.push_back('{i, exp_rd(i, a), name});
    endtask

    task automatic rd_check(input int i, input logic [10:0] a, input string name);
        push_rd(i, a, name);
        tick();
    endtask

    task automatic post_reset_checks(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_ready[%0d]", tag, i), {31'b0, ready_s[i]}, 32'h1);
            check($sformatf("%s_rd_data[%0d]", tag, i), rd_data_s[i], 32'h0);
`ifdef MEMORY_W_OOB_ERR_EN
            check($sformatf("%s_oob[%0d]", tag, i), {31'b0, oob_s[i]}, 32'h0);
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < 1024; a++) model[i][a] = 32'h0;
            start_s[i]   = 1'b0;
            addr_s[i]    = '0;
            din_s[i]     = '0;
            rd_addr_s[i] = '0;
        end
        for (int k = 0; k < 8; k++) begin
            burst[k] = '{11'(k), 32'hA000_0000 + 32'(k), 1'b1};
        end

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        post_reset_checks("reset");

        // Burst on WRITE_CYCLES=1: one write per edge, ready never drops.
        for (int k = 0; k < 8; k++) begin
            check($sformatf("burst_ready[%0d]", k), {31'b0, ready_s[0]}, {31'b0, burst[k].exp_ready});
            start_s[0] = 1'b1;
            addr_s[0]  = burst[k].addr;
            din_s[0]   = burst[k].data;
            tick();
            model[0][burst[k].addr[9:0]] = burst[k].data;
        end
        start_s[0] = 1'b0;
        check("burst_ready_end", {31'b0, ready_s[0]}, 32'h1);
        for (int k = 0; k < 8; k++) begin
            rd_check(0, burst[k].addr, $sformatf("burst_rd[%0d]", k));
        end

        // Read-during-write returns the old word.
        start_s[0] = 1'b1; addr_s[0] = 11'd3; din_s[0] = 32'h1111_1111;
        tick();
        model[0][3] = 32'h1111_1111;
        din_s[0] = 32'h2222_2222;
        push_rd(0, 11'd3, "rdw_old");
        tick();
        model[0][3] = 32'h2222_2222;
        start_s[0] = 1'b0;
        rd_check(0, 11'd3, "rdw_new");

        // Out-of-range write on WRITE_CYCLES=1.
`ifdef MEMORY_W_OOB_ERR_EN
        check("oob0_before", {31'b0, oob_s[0]}, 32'h0);
`endif
        start_s[0] = 1'b1; addr_s[0] = 11'd1024; din_s[0] = 32'hFFFF_FFFF;
        tick();
        start_s[0] = 1'b0; addr_s[0] = 11'd0; din_s[0] = 32'h0;
        check("oob0_ready", {31'b0, ready_s[0]}, 32'h1);
`ifdef MEMORY_W_OOB_ERR_EN
        check("oob0_set", {31'b0, oob_s[0]}, 32'h1);
`endif
        rd_check(0, 11'd0, "oob0_addr0");
        rd_check(0, 11'd1023, "oob0_addr1023");
        rd_check(0, 11'd1024, "oob0_rd_oob");
        rd_check(0, 11'd3, "oob0_addr3");
`ifdef MEMORY_W_OOB_ERR_EN
        check("oob0_sticky", {31'b0, oob_s[0]}, 32'h1);
`endif

        // WRITE_CYCLES=3: ready low for exactly two cycles; start while busy ignored.
        check("wc3_ready_idle", {31'b0, ready_s[1]}, 32'h1);
        start_s[1] = 1'b1; addr_s[1] = 11'd5; din_s[1] = 32'hDEAD_BEEF;
        tick();
        addr_s[1] = 11'd6; din_s[1] = 32'h1234_5678;
        check("wc3_busy1", {31'b0, ready_s[1]}, 32'h0);
        tick();
        start_s[1] = 1'b0; addr_s[1] = 11'd7; din_s[1] = 32'h0BAD_0BAD;
        check("wc3_busy2", {31'b0, ready_s[1]}, 32'h0);
        push_rd(1, 11'd5, "wc3_commit_edge_old");
        tick();
        model[1][5] = 32'hDEAD_BEEF;
        check("wc3_ready_back", {31'b0, ready_s[1]}, 32'h1);
        rd_check(1, 11'd5, "wc3_addr5");
        rd_check(1, 11'd6, "wc3_addr6_ignored");
        rd_check(1, 11'd7, "wc3_addr7");

        // Back-to-back writes on WRITE_CYCLES=3: one per three cycles.
        start_s[1] = 1'b1; addr_s[1] = 11'd6; din_s[1] = 32'h0000_600D;
        tick();
        addr_s[1] = 11'd8; din_s[1] = 32'h0000_0088;
        check("wc3_b2b_busy1", {31'b0, ready_s[1]}, 32'h0);
        tick();
        check("wc3_b2b_busy2", {31'b0, ready_s[1]}, 32'h0);
        tick();
        check("wc3_b2b_ready", {31'b0, ready_s[1]}, 32'h1);
        model[1][6] = 32'h0000_600D;
        tick();
        start_s[1] = 1'b0;
        check("wc3_b2b_busy3", {31'b0, ready_s[1]}, 32'h0);
        tick();
        tick();
        model[1][8] = 32'h0000_0088;
        check("wc3_b2b_ready2", {31'b0, ready_s[1]}, 32'h1);
        rd_check(1, 11'd6, "wc3_addr6");
        rd_check(1, 11'd8, "wc3_addr8");

        // Out-of-range write on WRITE_CYCLES=3 keeps normal busy timing and does not wrap.
        start_s[1] = 1'b1; addr_s[1] = 11'd2047; din_s[1] = 32'hFFFF_FFFF;
        tick();
        start_s[1] = 1'b0;
`ifdef MEMORY_W_OOB_ERR_EN
        check("oob1_set", {31'b0, oob_s[1]}, 32'h1);
`endif
        check("oob1_busy", {31'b0, ready_s[1]}, 32'h0);
        tick();
        tick();
        check("oob1_ready", {31'b0, ready_s[1]}, 32'h1);
        rd_check(1, 11'd1023, "oob1_addr1023");
        rd_check(1, 11'd5, "oob1_addr5");

        // WRITE_CYCLES=4: prior value, then a write abandoned by reset.
        start_s[2] = 1'b1; addr_s[2] = 11'd9; din_s[2] = 32'h0000_0077;
        tick();
        start_s[2] = 1'b0;
        tick();
        tick();
        check("wc4_busy3", {31'b0, ready_s[2]}, 32'h0);
        tick();
        model[2][9] = 32'h0000_0077;
        check("wc4_ready", {31'b0, ready_s[2]}, 32'h1);
        rd_check(2, 11'd9, "wc4_prior");

        start_s[2] = 1'b1; addr_s[2] = 11'd9; din_s[2] = 32'h0000_0055;
        tick();
        start_s[2] = 1'b0;
        check("wc4_accept", {31'b0, ready_s[2]}, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        post_reset_checks("midrst");
        for (int k = 0; k < 6; k++) tick();
        rd_check(2, 11'd9, "midrst_addr9");
        rd_check(0, 11'd3, "midrst_keep_addr3");
        rd_check(1, 11'd5, "midrst_keep_addr5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_write_ram.md
Name: memory_write_ram

Overview:
- Single-port-write word RAM that sits behind the output-stream writer.
- Each accepted `start` pulse stores `data_in` at `address`.
- `ready` tells the producer when a new write may be issued.
- A synchronous read port is provided for readback and verification.

Parameters:
- SIZE, default 1024: number of words in the array. Valid addresses are 0..SIZE-1.
- ADDRESS_WIDTH, default 10: width of `address` and `rd_addr`. Must satisfy 2^ADDRESS_WIDTH >= SIZE.
- write_size, default 32: word width in bits; width of `data_in` and `rd_data`.
- WRITE_CYCLES, default 1: cycles from acceptance to commit. Must be >= 1.

Ports:
- clk  in  1: single clock; all logic on its rising edge.
- reset  in  1: synchronous, active-high reset.
- start  in  1: write request, sampled on the rising edge of `clk`.
- address  in  ADDRESS_WIDTH: write word address.
- data_in  in  write_size: write data.
- ready  out  1: high when a write can be accepted this cycle.
- rd_addr  in  ADDRESS_WIDTH: read word address.
- rd_data  out  write_size: registered read data.
- oob_err  out  1: sticky out-of-range flag. Present only with MEMORY_W_OOB_ERR_EN.

Behaviour:
- Reset (reset=1 at a `clk` edge):
  - `ready` becomes 1, `rd_data` becomes 0, `oob_err` becomes 0.
  - Any in-flight write is abandoned and never committed.
  - Array contents are not cleared by reset. They are initialised to 0 at time zero for simulation only.
- Acceptance: a write is accepted on an edge where reset=0, start=1 and ready=1. `address` and `data_in` are captured on that edge.
- WRITE_CYCLES=1:
  - The word is committed on the accepting edge.
  - `ready` stays 1 permanently outside reset.
  - Back-to-back writes every cycle are supported with zero stalls.
- WRITE_CYCLES=N>1: two-state machine, IDLE and BUSY.
  - IDLE -> BUSY on acceptance. `ready` drops to 0 on the following cycle. An internal counter is loaded with N-1.
  - In BUSY the counter decrements each edge. The captured word is committed on the edge where the counter reaches 0.
  - BUSY -> IDLE on that commit edge, so `ready` is 1 again in the next cycle.
  - Throughput is one write per N cycles.
  - `start` while ready=0 is ignored: no queuing and no error.
  - Changing `address` or `data_in` during BUSY has no effect on the in-flight write.
- Out-of-range address (address >= SIZE):
  - The write is accepted, follows normal ready/busy timing, and is dropped at commit.
  - The array is never modified and the address does not wrap.
- Read port:
  - `rd_data` <= mem[rd_addr] on every non-reset edge; one-cycle latency.
  - If the read and a commit hit the same address on the same edge, `rd_data` returns the old contents (read-before-write). The new value is visible on the next read.
  - `rd_addr` >= SIZE returns 0.
- Full-width, no masking: the entire write_size-bit word is written.

Optional Feature:
- Macro name: MEMORY_W_OOB_ERR_EN.
- When defined:
  - The `oob_err` port exists.
  - `oob_err` is set to 1 on the acceptance edge of any write with address >= SIZE.
  - It stays 1 until reset. Writes still drop as described above.
- When undefined: the port and its logic are absent, and out-of-range writes are silently dropped.

Test Plan:
- Reset check: assert reset for 2 cycles, then release -> ready=1, rd_data=0, and oob_err=0 when the feature is built in.
- Burst writes, WRITE_CYCLES=1:
  - Stimulus: start=1 for 8 consecutive cycles with address 0..7 and data_in 0xA0000000+i.
  - Response: ready stays 1 throughout. Reading addresses 0..7 returns 0xA0000000..0xA0000007, each one cycle after `rd_addr` is applied.
- Busy behaviour, WRITE_CYCLES=3:
  - Stimulus: write 0xDEADBEEF to address 5, then pulse start with 0x12345678 to address 6 on the next cycle.
  - Response: ready is 0 for exactly 2 cycles. Address 6 is unchanged (0). Address 5 = 0xDEADBEEF after the commit.
- Read-during-write:
  - Stimulus: address 3 holds 0x11111111. Write 0x22222222 to address 3 with rd_addr=3 on the same edge.
  - Response: rd_data=0x11111111. The next read returns 0x22222222.
- Out-of-range write:
  - Stimulus: SIZE=1024, write 0xFFFFFFFF to address 1024 with ADDRESS_WIDTH=11.
  - Response: no in-range word changes, address 0 is untouched, and oob_err=1 until reset (with the feature built in).
- Reset mid-write:
  - Stimulus: WRITE_CYCLES=4; accept a write of 0x55 to address 9, then assert reset 1 cycle later.
  - Response: ready=1 after reset, and address 9 still holds its prior value.
